compare_window_stats: RTL

Downstream consumer of the 4-bit magnitude comparator. Accepts one comparison per handshake: operands A/B plus the comparator's EQ/GT/LT flags. Each flag set is cross-checked against a locally computed reference. Over a fixed window of accepted samples, the block counts EQ, GT, LT and erroneous results and tracks the largest A. It then emits one summary record over a valid/ready handshake, for self-checking and bring-up monitoring of the comparator path.

---
 rtl/compare_window_stats.sv | 119 +++++++++++
 1 files changed

// File: rtl/compare_window_stats.sv
// compare_window_stats: cross-checks comparator flags against a local reference and
// reports EQ/GT/LT/error counts plus max A over each window of accepted samples.
module compare_window_stats #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_eq_b,
    input  logic             a_gt_b,
    input  logic             a_lt_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] rpt_eq,
    output logic [CNT_W-1:0] rpt_gt,
    output logic [CNT_W-1:0] rpt_lt,
    output logic [CNT_W-1:0] rpt_err,
    output logic [WIDTH-1:0] rpt_max_a
);
    typedef enum logic {ACCUM, REPORT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] eq_q, eq_d, gt_q, gt_d, lt_q, lt_d, err_q, err_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] rpt_eq_q, rpt_eq_d, rpt_gt_q, rpt_gt_d, rpt_lt_q, rpt_lt_d;
    logic [CNT_W-1:0] rpt_err_q, rpt_err_d;
    logic [WIDTH-1:0] rpt_max_q, rpt_max_d;
    logic [2:0]       exp_f;
    logic             hit, accept, flush;

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == REPORT;
    assign rpt_eq    = rpt_eq_q;
    assign rpt_gt    = rpt_gt_q;
    assign rpt_lt    = rpt_lt_q;
    assign rpt_err   = rpt_err_q;
    assign rpt_max_a = rpt_max_q;

    assign exp_f  = {a == b, a > b, a < b};
    assign hit    = {a_eq_b, a_gt_b, a_lt_b} == exp_f;
    assign accept = in_valid && in_ready;
    // clear outranks both the accept and the report handshake
    assign flush  = clear || (out_valid && out_ready);

    always_comb begin
        state_d   = state_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        rpt_eq_d  = rpt_eq_q;
        rpt_gt_d  = rpt_gt_q;
        rpt_lt_d  = rpt_lt_q;
        rpt_err_d = rpt_err_q;
        rpt_max_d = rpt_max_q;
        if (flush) begin
            state_d = ACCUM;
            eq_d    = '0;
            gt_d    = '0;
            lt_d    = '0;
            err_d   = '0;
            cnt_d   = '0;
            max_d   = '0;
        end else if (accept) begin
            eq_d  = eq_q + CNT_W'(hit && exp_f[2]);
            gt_d  = gt_q + CNT_W'(hit && exp_f[1]);
            lt_d  = lt_q + CNT_W'(hit && exp_f[0]);
            err_d = err_q + CNT_W'(!hit);
            max_d = (cnt_q == '0 || a > max_q) ? a : max_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(WINDOW)) begin
                state_d   = REPORT;
                rpt_eq_d  = eq_d;
                rpt_gt_d  = gt_d;
                rpt_lt_d  = lt_d;
                rpt_err_d = err_d;
                rpt_max_d = max_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            eq_q      <= '0;
            gt_q      <= '0;
            lt_q      <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            rpt_eq_q  <= '0;
            rpt_gt_q  <= '0;
            rpt_lt_q  <= '0;
            rpt_err_q <= '0;
            rpt_max_q <= '0;
        end else begin
            state_q   <= state_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            rpt_eq_q  <= rpt_eq_d;
            rpt_gt_q  <= rpt_gt_d;
            rpt_lt_q  <= rpt_lt_d;
            rpt_err_q <= rpt_err_d;
            rpt_max_q <= rpt_max_d;
        end
    end
endmodule
